// File: rtl/contador_eventos_multi_if.sv
// contador_eventos_multi_if: event inputs, controls and readout of the multi-channel event counter
interface contador_eventos_multi_if #(
  parameter int NCH = 4,
  parameter int N = 3
);
  localparam int SW = NCH > 1 ? $clog2(NCH) : 1;
  logic [NCH-1:0] ev;
  logic en;
  logic dir;
  logic [NCH-1:0] clr;
  logic [NCH-1:0] ov_clr;
  logic [SW-1:0] sel;
  logic [N-1:0] data;
  logic [NCH-1:0] ov;
  logic ov_any;
  modport master (output ev, en, dir, clr, ov_clr, sel, input data, ov, ov_any);
  modport slave (input ev, en, dir, clr, ov_clr, sel, output data, ov, ov_any);
endinterface

// File: rtl/contador_eventos_multi.sv
// contador_eventos_multi: per-channel synchronized edge counters modulo M with sticky wrap flags and muxed readout
module contador_eventos_multi #(
  parameter int NCH = 4,
  parameter int N = 3,
  parameter int M = 8
) (
  input logic clk,
  input logic rst,
  contador_eventos_multi_if.slave bus
);
  localparam int SW = NCH > 1 ? $clog2(NCH) : 1;
  localparam logic [N-1:0] CMAX = N'(M - 1);
  localparam logic [SW:0] NCH_W = (SW + 1)'(NCH);
  logic [NCH-1:0] s1, s2, s3, tic, ov_r;
  logic [NCH-1:0][N-1:0] cnt;
  logic [N-1:0] data_r;
  // two-flop synchronizer plus a third flop for rising-edge detection
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= bus.ev;
      s2 <= s1;
      s3 <= s2;
    end
  assign tic = s2 & ~s3;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [N-1:0] c, nxt;
    logic hit, wrap, o;
    assign hit = tic[i] & bus.en;
    assign wrap = bus.dir ? c == '0 : c == CMAX;
    assign nxt = bus.dir ? (wrap ? CMAX : c - 1'b1) : (wrap ? '0 : c + 1'b1);
    // counter: clear beats a same-cycle tic; flag set beats a same-cycle flag clear
    always_ff @(posedge clk)
      if (rst) begin
        c <= '0;
        o <= 1'b0;
      end else begin
        c <= bus.clr[i] ? '0 : hit ? nxt : c;
        o <= (hit & ~bus.clr[i] & wrap) | (o & ~bus.ov_clr[i]);
      end
    assign cnt[i] = c;
    assign ov_r[i] = o;
  end
  // registered readout of the selected channel, zero for selects past the last channel
  always_ff @(posedge clk)
    data_r <= rst ? '0 : ({1'b0, bus.sel} < NCH_W) ? cnt[bus.sel] : '0;
  assign bus.data = data_r;
  assign bus.ov = ov_r;
  assign bus.ov_any = |ov_r;
endmodule

// File: tb/tb_contador_eventos_multi.sv
// tb_contador_eventos_multi: directed stimulus with a scoreboard queue checked by an independent monitor
module tb_contador_eventos_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] ev = '0, clr = '0, ov_clr = '0;
  logic en = 1'b1, dir = 1'b0;
  logic [1:0] sel = '0;
  logic [2:0] sel2 = '0;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    string tag;
    bit use_main;
    logic [2:0] d;
    logic [2:0] d2;
    logic [3:0] ov;
  } exp_t;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  contador_eventos_multi_if #(.NCH(4), .N(3)) if0 ();
  contador_eventos_multi_if #(.NCH(5), .N(3)) if1 ();
  assign if0.ev = ev;
  assign if0.en = en;
  assign if0.dir = dir;
  assign if0.clr = clr;
  assign if0.ov_clr = ov_clr;
  assign if0.sel = sel;
  assign if1.ev = {1'b0, ev};
  assign if1.en = en;
  assign if1.dir = dir;
  assign if1.clr = {1'b0, clr};
  assign if1.ov_clr = {1'b0, ov_clr};
  assign if1.sel = sel2;

  contador_eventos_multi #(.NCH(4), .N(3), .M(8)) u0 (.clk(clk), .rst(rst), .bus(if0));
  contador_eventos_multi #(.NCH(5), .N(3), .M(8)) u1 (.clk(clk), .rst(rst), .bus(if1));

  always @(negedge clk)
    if (q.size() != 0) begin
      e = q.pop_front();
      vectors++;
      if (e.use_main && if0.data !== e.d) begin
        miscompares++;
        $display("FAIL %s data: got %0d want %0d", e.tag, if0.data, e.d);
      end
      if (if1.data !== e.d2) begin
        miscompares++;
        $display("FAIL %s data5ch: got %0d want %0d", e.tag, if1.data, e.d2);
      end
      if (if0.ov !== e.ov) begin
        miscompares++;
        $display("FAIL %s ov: got %b want %b", e.tag, if0.ov, e.ov);
      end
      if (if0.ov_any !== |e.ov) begin
        miscompares++;
        $display("FAIL %s ov_any: got %b want %b", e.tag, if0.ov_any, |e.ov);
      end
    end

  task automatic drain(input string tag);
    int k = 0;
    while (q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL %s timeout: got %0d pending want 0", tag, q.size());
      q.delete();
    end
  endtask

  task automatic chk(input string tag, input int ch, input logic [2:0] d, input logic [3:0] o);
    sel = ch[1:0];
    sel2 = ch[2:0];
    @(posedge clk);
    q.push_back('{tag, ch < 4, d, ch < 4 ? d : 3'd0, o});
    drain(tag);
  endtask

  task automatic pulse(input logic [3:0] m, input logic [3:0] cm = '0, input logic [3:0] om = '0);
    ev = m;
    @(posedge clk);
    @(posedge clk);
    #1 clr = cm;
    ov_clr = om;
    @(posedge clk);
    #1 clr = '0;
    ov_clr = '0;
    ev = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic flag_clear(input logic [3:0] m);
    ov_clr = m;
    @(posedge clk);
    #1 ov_clr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset", 0, 3'd0, 4'b0000);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      pulse(4'b0001);
      chk($sformatf("up%0d", k), 0, 3'(k % 8), k == 8 ? 4'b0001 : 4'b0000);
    end
    for (int c = 1; c < 4; c++) chk($sformatf("idle_ch%0d", c), c, 3'd0, 4'b0001);

    do_reset();
    dir = 1'b1;
    pulse(4'b0100);
    chk("down_wrap", 2, 3'd7, 4'b0100);
    pulse(4'b0100);
    chk("down_6", 2, 3'd6, 4'b0100);
    flag_clear(4'b0100);
    chk("ov_clr2", 2, 3'd6, 4'b0000);

    do_reset();
    dir = 1'b0;
    for (int k = 0; k < 5; k++) pulse(4'b0010);
    chk("ch1_5", 1, 3'd5, 4'b0000);
    pulse(4'b0010, 4'b0010);
    chk("clr_vs_tic", 1, 3'd0, 4'b0000);
    for (int k = 0; k < 8; k++) pulse(4'b1000);
    chk("ch3_wrap", 3, 3'd0, 4'b1000);
    for (int k = 0; k < 7; k++) pulse(4'b1000);
    chk("ch3_7", 3, 3'd7, 4'b1000);
    pulse(4'b1000, 4'b0000, 4'b1000);
    chk("set_beats_clr", 3, 3'd0, 4'b1000);
    flag_clear(4'b1000);
    chk("ov_clr3", 3, 3'd0, 4'b0000);
    chk("ch1_stays0", 1, 3'd0, 4'b0000);

    do_reset();
    pulse(4'b1111);
    en = 1'b0;
    pulse(4'b1111);
    en = 1'b1;
    for (int c = 0; c < 4; c++) chk($sformatf("all_ch%0d", c), c, 3'd1, 4'b0000);
    chk("sel4", 4, 3'd0, 4'b0000);
    chk("sel5", 5, 3'd0, 4'b0000);
    dir = 1'b1;
    pulse(4'b0001);
    chk("dir_flip", 0, 3'd0, 4'b0000);
    dir = 1'b0;

    ev = 4'b0001;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    chk("mid_rst_a", 0, 3'd0, 4'b0000);
    chk("mid_rst_b", 1, 3'd0, 4'b0000);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rel_edge3", 0, 3'd0, 4'b0000);
    chk("rel_edge4", 0, 3'd1, 4'b0000);
    ev = '0;
    repeat (5) @(posedge clk);
    #1;
    chk("rel_once", 0, 3'd1, 4'b0000);
    chk("rel_ch2", 2, 3'd0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/contador_eventos_multi.md
CONTADOR_EVENTOS_MULTI -- requirements
Module: contador_eventos_multi

Interface
REQ-001 Parameter NCH, default 4, number of independent event channels (1..16).
REQ-002 Parameter N, default 3, counter width in bits per channel.
REQ-003 Parameter M, default 8, count modulus per channel, 2 <= M <= 2**N.
REQ-004 The module SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset, clears all state.
REQ-007 ev  input  NCH  asynchronous raw event lines, one per channel.
REQ-008 en  input  1  global count enable; 1 = detected events are counted.
REQ-009 dir  input  1  count direction for all channels; 0 = up, 1 = down.
REQ-010 clr  input  NCH  per-channel synchronous counter clear.
REQ-011 ov_clr  input  NCH  per-channel sticky overflow flag clear.
REQ-012 sel  input  max(1,$clog2(NCH))  channel select for data readout.
REQ-013 data  output  N  registered count of channel sel.
REQ-014 ov  output  NCH  per-channel sticky overflow/underflow flags.
REQ-015 ov_any  output  1  OR of all ov bits.

Function
REQ-016 Each channel SHALL pass ev[i] through a two-flop synchronizer followed by a third flop; tic[i] = stage2 AND NOT stage3.
REQ-017 If t is the first clk edge sampling ev[i]=1 after a low period, the channel counter SHALL update on edge t+2; one count per rising edge of ev[i], regardless of high-pulse length.
REQ-018 ev[i] high or low periods shorter than 2 clk cycles are not guaranteed to be counted.
REQ-019 tic[i] with en=1, clr[i]=0, dir=0: count[i] <= count[i]+1 when count[i] < M-1, else count[i] <= 0 and ov[i] <= 1.
REQ-020 tic[i] with en=1, clr[i]=0, dir=1: count[i] <= count[i]-1 when count[i] > 0, else count[i] <= M-1 and ov[i] <= 1.
REQ-021 tic[i] with en=0 SHALL be dropped: no count change, no flag change, no queuing.
REQ-022 clr[i]=1 SHALL set count[i] <= 0 on the next edge and take priority over a same-cycle tic[i]; ov[i] is not set by that tic.
REQ-023 ov[i] SHALL remain 1 until ov_clr[i]=1 or rst; ov_clr[i] and a same-cycle wrap SHALL leave ov[i]=1 (set wins).
REQ-024 Channels SHALL be fully independent; simultaneous tics on any subset of channels SHALL all be counted in the same cycle.
REQ-025 dir SHALL be sampled every cycle; a change applies to the next counted tic with no additional latency.
REQ-026 data SHALL equal count[sel] as of the previous edge, registered: 1-cycle latency from a sel change or a count update.
REQ-027 sel >= NCH SHALL yield data = 0.
REQ-028 ov_any SHALL be combinational OR of the registered ov bits, with no added latency.
REQ-029 Counter arithmetic SHALL stay within N bits; values >= M SHALL be unreachable.

Reset
REQ-030 rst=1 at an edge SHALL set all counters 0, all ov 0, data 0, and all synchronizer/edge flops 0; rst has priority over every other input.
REQ-031 An ev[i] held high across reset release SHALL be counted exactly once, at the third edge after rst is deasserted.
REQ-032 Reset mid-operation SHALL discard any in-flight tic in the synchronizer.

Verification
REQ-033 Defaults, dir=0, en=1: 8 clean pulses on ev[0] -> count[0] goes 1..7,0; ov[0]=1 after the 8th; ov_any=1; other channels 0.
REQ-034 dir=1 from reset, one pulse on ev[2] -> count[2]=7, ov[2]=1; a second pulse -> 6.
REQ-035 ev[1] rises so that tic[1] coincides with clr[1]=1 at count 5 -> count[1]=0, ov[1] unchanged; same-cycle ov_clr[3] with channel 3 wrap -> ov[3]=1.
REQ-036 Simultaneous pulses on all 4 channels with en=1, then one more pulse with en=0 -> every count = 1.
REQ-037 Sweep sel 0..3 and then sel=5 -> data tracks count[sel] one cycle later; sel=5 gives 0.
REQ-038 Assert rst mid-pulse with ev[0] held high across release -> all outputs 0 during reset; count[0]=1 three edges after release.
